// File: rtl/proto_pkg.sv
// rtl/proto_pkg.sv - shared state encoding, byte width and checksum helper for protocol_frame_rx
//
// Contents: BYTE_W constant, rx_state_t FSM encoding, frame_checksum().
// Configuration macro: PROTO_CHECKSUM_EN adds the ST_CHK state.
package proto_pkg;

    localparam int BYTE_W = 8;

`ifdef PROTO_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_ADDR = 2'd0,
        ST_CMD  = 2'd1,
        ST_CHK  = 2'd2,
        ST_HOLD = 2'd3
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        ST_ADDR = 2'd0,
        ST_CMD  = 2'd1,
        ST_HOLD = 2'd3
    } rx_state_t;
`endif

    // Third frame byte expected when the checksum is enabled.
    function automatic logic [BYTE_W-1:0] frame_checksum(
        input logic [BYTE_W-1:0] b1,
        input logic [BYTE_W-1:0] b2
    );
        return b1 ^ b2;
    endfunction

endpackage

// File: rtl/proto_gap_timer.sv
// rtl/proto_gap_timer.sv - inter-byte gap counter with expiry flag
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       restart the gap count (a byte was accepted)
//   en        count this cycle (a frame is partially received)
//   expired   count has reached TIMEOUT_CYC-1 while enabled
module proto_gap_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a paused-but-expired count never wraps back to
    // a small value; the next accepted byte restarts it anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/protocol_frame_rx.sv
// rtl/protocol_frame_rx.sv - byte-stream frame decoder (address, command, optional checksum)
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   rx_done, rx_data[7:0]         received byte strobe and value
//   out_valid, out_ready          decoded frame handshake
//   out_addr[ADDR_W-1:0]          low bits of byte 1
//   out_cmd[CMD_W-1:0]            low bits of byte 2
//   err_addr, err_timeout,
//   err_overrun                   one-cycle error pulses
//   err_chk                       checksum mismatch pulse (PROTO_CHECKSUM_EN only)
// Configuration macro: PROTO_CHECKSUM_EN requires byte3 == byte1 ^ byte2.
module protocol_frame_rx
    import proto_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int CMD_W       = 3,
    parameter int NUM_SENSORS = 32,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CMD_W-1:0]  out_cmd,
    output logic              err_addr,
    output logic              err_timeout,
    output logic              err_overrun
`ifdef PROTO_CHECKSUM_EN
    ,
    output logic              err_chk
`endif
);

    rx_state_t state;
    rx_state_t state_nxt;

    logic cap_addr;
    logic cap_cmd;
    logic addr_bad;
    logic timeout_hit;
    logic overrun_hit;
    logic gap_clr;
    logic gap_en;
    logic gap_expired;
    logic addr_ok;

    // Range check covers the whole byte, not just the captured low bits.
    assign addr_ok = (32'(rx_data) < NUM_SENSORS);

`ifdef PROTO_CHECKSUM_EN
    logic [BYTE_W-1:0] b1_q;
    logic [BYTE_W-1:0] b2_q;
    logic              chk_bad;

    assign gap_en = (state == ST_CMD) || (state == ST_CHK);
`else
    logic [ADDR_W-1:0] addr_q;
    logic [CMD_W-1:0]  cmd_q;

    assign gap_en = (state == ST_CMD);
`endif

    proto_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (gap_clr),
        .en     (gap_en),
        .expired(gap_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ADDR;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt   = state;
        cap_addr    = 1'b0;
        cap_cmd     = 1'b0;
        addr_bad    = 1'b0;
        timeout_hit = 1'b0;
        overrun_hit = 1'b0;
        gap_clr     = 1'b0;
`ifdef PROTO_CHECKSUM_EN
        chk_bad     = 1'b0;
`endif
        case (state)
            ST_ADDR: begin
                if (rx_done) begin
                    if (addr_ok) begin
                        cap_addr  = 1'b1;
                        gap_clr   = 1'b1;
                        state_nxt = ST_CMD;
                    end else begin
                        addr_bad  = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (rx_done) begin
                    cap_cmd = 1'b1;
                    gap_clr = 1'b1;
`ifdef PROTO_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_HOLD;
`endif
                end else if (gap_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_ADDR;
                end
            end
`ifdef PROTO_CHECKSUM_EN
            ST_CHK: begin
                if (rx_done) begin
                    gap_clr = 1'b1;
                    if (rx_data == frame_checksum(b1_q, b2_q)) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        chk_bad   = 1'b1;
                        state_nxt = ST_ADDR;
                    end
                end else if (gap_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_ADDR;
                end
            end
`endif
            ST_HOLD: begin
                // The held frame is never overwritten; extra bytes are dropped.
                if (rx_done) begin
                    overrun_hit = 1'b1;
                end
                if (out_ready) begin
                    state_nxt = ST_ADDR;
                end
            end
            default: begin
                state_nxt = ST_ADDR;
            end
        endcase
    end

    // Captured fields only change in ADDR/CMD, so they are stable in HOLD.
`ifdef PROTO_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            b1_q <= '0;
            b2_q <= '0;
        end else begin
            if (cap_addr) begin
                b1_q <= rx_data;
            end
            if (cap_cmd) begin
                b2_q <= rx_data;
            end
        end
    end

    assign out_addr = b1_q[ADDR_W-1:0];
    assign out_cmd  = b2_q[CMD_W-1:0];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            cmd_q  <= '0;
        end else begin
            if (cap_addr) begin
                addr_q <= rx_data[ADDR_W-1:0];
            end
            if (cap_cmd) begin
                cmd_q <= rx_data[CMD_W-1:0];
            end
        end
    end

    assign out_addr = addr_q;
    assign out_cmd  = cmd_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef PROTO_CHECKSUM_EN
            err_chk     <= 1'b0;
`endif
        end else begin
            err_addr    <= addr_bad;
            err_timeout <= timeout_hit;
            err_overrun <= overrun_hit;
`ifdef PROTO_CHECKSUM_EN
            err_chk     <= chk_bad;
`endif
        end
    end

    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_protocol_frame_rx.sv
// tb/tb_protocol_frame_rx.sv - self-checking bench for protocol_frame_rx
`timescale 1ns/1ps
module tb_protocol_frame_rx;

    localparam int ADDR_W      = 5;
    localparam int CMD_W       = 3;
    localparam int NUM_SENSORS = 32;
    localparam int TIMEOUT_CYC = 1000;
`ifdef PROTO_CHECKSUM_EN
    localparam int FRAME_LEN = 3;
`else
    localparam int FRAME_LEN = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_done = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [CMD_W-1:0]  out_cmd;
    logic              err_addr;
    logic              err_timeout;
    logic              err_overrun;
`ifdef PROTO_CHECKSUM_EN
    logic              err_chk;
`endif

    protocol_frame_rx #(
        .ADDR_W     (ADDR_W),
        .CMD_W      (CMD_W),
        .NUM_SENSORS(NUM_SENSORS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_cmd    (out_cmd),
        .err_addr   (err_addr),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
`ifdef PROTO_CHECKSUM_EN
        ,
        .err_chk    (err_chk)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, let one edge consume them, sample 1ns later.
    task automatic step(input logic d, input logic [7:0] data, input logic rdy);
        rx_done   = d;
        rx_data   = data;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input int a, input int c,
                             input logic ea, input logic et, input logic eo, input logic ec);
        check({tag, ".valid"}, int'(out_valid), int'(v));
        if (v) begin
            check({tag, ".addr"}, int'(out_addr), a % (2 ** ADDR_W));
            check({tag, ".cmd"},  int'(out_cmd),  c % (2 ** CMD_W));
        end
        check({tag, ".err_addr"},    int'(err_addr),    int'(ea));
        check({tag, ".err_timeout"}, int'(err_timeout), int'(et));
        check({tag, ".err_overrun"}, int'(err_overrun), int'(eo));
`ifdef PROTO_CHECKSUM_EN
        check({tag, ".err_chk"}, int'(err_chk), int'(ec));
`else
        if (ec) check({tag, ".err_chk_unexpected"}, 0, 1);
`endif
    endtask

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       rdy;
        logic       v;
        int         a;
        int         c;
        logic       ea;
        logic       eo;
    } vec_t;

    vec_t vt[$];

    // Reference model: bytes of the partial frame, cycle of the last accepted byte,
    // and the frame currently offered to the consumer.
    int         m_nb;
    logic [7:0] m_fb[3];
    int         m_last;
    int         m_cyc;
    bit         m_hold;
    int         m_ha;
    int         m_hc;

    task automatic model_cycle(input logic d, input logic [7:0] data, input logic rdy);
        logic e_a = 1'b0;
        logic e_t = 1'b0;
        logic e_o = 1'b0;
        logic e_c = 1'b0;
        if (m_hold) begin
            if (d) e_o = 1'b1;
            if (rdy) m_hold = 1'b0;
        end else if (m_nb == 0) begin
            if (d) begin
                if (int'(data) < NUM_SENSORS) begin
                    m_fb[0] = data;
                    m_nb    = 1;
                    m_last  = m_cyc;
                end else begin
                    e_a = 1'b1;
                end
            end
        end else if (d) begin
            m_fb[m_nb] = data;
            m_nb++;
            m_last = m_cyc;
            if (m_nb == FRAME_LEN) begin
                m_nb = 0;
                if (FRAME_LEN == 3 && m_fb[2] != (m_fb[0] ^ m_fb[1])) begin
                    e_c = 1'b1;
                end else begin
                    m_hold = 1'b1;
                    m_ha   = int'(m_fb[0]);
                    m_hc   = int'(m_fb[1]);
                end
            end
        end else if (m_cyc - m_last >= TIMEOUT_CYC) begin
            e_t  = 1'b1;
            m_nb = 0;
        end
        step(d, data, rdy);
        check_out($sformatf("rand@%0d", m_cyc), m_hold, m_ha, m_hc, e_a, e_t, e_o, e_c);
        m_cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int early;
        int idle_left;

        // Reset state
        do_reset();
        check("reset.valid", int'(out_valid), 0);
        check("reset.addr",  int'(out_addr), 0);
        check("reset.cmd",   int'(out_cmd), 0);
        check_out("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table: basic frame, bad address then good frame, overrun while held.
`ifdef PROTO_CHECKSUM_EN
        vt.push_back(vec_t'{1'b1, 8'h07, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b1, 8'h05, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b1, 8'h02, 1'b1, 1'b1, 7, 5, 1'b0, 1'b0});
`else
        vt.push_back(vec_t'{1'b1, 8'h07, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b1, 8'h05, 1'b1, 1'b1, 7, 5, 1'b0, 1'b0});
`endif
        vt.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b1, 8'h25, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0});
        vt.push_back(vec_t'{1'b1, 8'h03, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
`ifdef PROTO_CHECKSUM_EN
        vt.push_back(vec_t'{1'b1, 8'h01, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b1, 8'h02, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0});
`else
        vt.push_back(vec_t'{1'b1, 8'h01, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0});
`endif
        vt.push_back(vec_t'{1'b1, 8'h11, 1'b0, 1'b1, 3, 1, 1'b0, 1'b1});
        vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
        vt.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
        foreach (vt[i]) begin
            step(vt[i].rd, vt[i].data, vt[i].rdy);
            check_out($sformatf("table[%0d]", i), vt[i].v, vt[i].a, vt[i].c,
                      vt[i].ea, 1'b0, vt[i].eo, 1'b0);
        end

        // Timeout: 1000 idle cycles after the address byte.
        step(1'b1, 8'h02, 1'b1);
        early = 0;
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if (err_timeout || out_valid) early++;
        end
        check("timeout.early", early, 0);
        step(1'b0, 8'h00, 1'b1);
        check_out("timeout.pulse", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_out("timeout.after", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Byte on the expiry cycle wins over the timeout.
        step(1'b1, 8'h02, 1'b0);
        for (int k = 1; k < TIMEOUT_CYC; k++) step(1'b0, 8'h00, 1'b0);
`ifdef PROTO_CHECKSUM_EN
        step(1'b1, 8'h05, 1'b0);
        check_out("edge.cmd", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0);
`else
        step(1'b1, 8'h05, 1'b0);
`endif
        check_out("edge.frame", 1'b1, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_out("edge.release", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while in CMD, then a full frame.
        step(1'b1, 8'h04, 1'b0);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        check("rst_cmd.valid", int'(out_valid), 0);
        check("rst_cmd.addr",  int'(out_addr), 0);
        step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'h02, 1'b0);
`ifdef PROTO_CHECKSUM_EN
        step(1'b1, 8'h0b, 1'b0);
`endif
        check_out("rst_cmd.frame", 1'b1, 9, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while holding, with a colliding byte and ready.
        rst = 1'b1;
        step(1'b1, 8'h11, 1'b1);
        rst = 1'b0;
        check("rst_hold.cmd", int'(out_cmd), 0);
        check_out("rst_hold", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PROTO_CHECKSUM_EN
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h06, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        check_out("chk.good", 1'b1, 4, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h04, 1'b1);
        step(1'b1, 8'h06, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        check_out("chk.bad", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_out("chk.after", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic against the reference model, with a few long gaps.
        do_reset();
        m_nb = 0; m_last = 0; m_cyc = 0; m_hold = 1'b0; m_ha = 0; m_hc = 0;
        idle_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       d;
            logic [7:0] data;
            logic       rdy;
            if (i % 700 == 350) idle_left = $urandom_range(TIMEOUT_CYC - 2, TIMEOUT_CYC + 1);
            if (idle_left > 0) begin
                idle_left--;
                d = 1'b0;
            end else begin
                d = ($urandom_range(0, 9) < 4);
            end
            data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 39));
            rdy  = 1'($urandom_range(0, 1));
            model_cycle(d, data, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
